thread_switch_controller: RTL and testbench
===========================================

THREAD_SWITCH_CONTROLLER -- requirements
Module: thread_switch_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all PC values.
REQ-002 Parameter MIN_RUN, default 4, minimum cycles a thread runs after a switch before another switch is permitted (range 1-255).
REQ-003 Parameter RESET_PC0, default 32'h0, initial PC of thread 0.
REQ-004 Parameter RESET_PC1, default 32'h100, initial PC of thread 1.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 thread_en  in  2  per-thread enable mask; stable outside reset; bit0 SHALL be 1.
REQ-008 dc_miss  in  1  one-cycle pulse: D-cache miss for the current thread in MEM.
REQ-009 miss_pc  in  ADDR_WIDTH  PC of the missing instruction, valid with dc_miss.
REQ-010 mem_done  in  1  one-cycle pulse: fill complete.
REQ-011 mem_done_tid  in  1  thread owning the completed fill, valid with mem_done.
REQ-012 cur_tid  out  1  thread currently issuing.
REQ-013 thread_switch  out  1  one-cycle pulse: flush all stages, switching threads.
REQ-014 thread_switch_available  out  1  other thread can be switched to this cycle.
REQ-015 load_pc_we  out  1  PC overwrite strobe, asserted only with thread_switch.
REQ-016 load_pc_new_pc  out  ADDR_WIDTH  resume PC of incoming thread.
REQ-017 switch_count  out  16  number of switches since reset.

Function
REQ-018 Per-thread status SHALL be READY, WAITING (miss outstanding) or IDLE (thread_en bit 0); per-thread saved_pc register.
REQ-019 Controller FSM SHALL have states RUN, SWITCH, STALL.
REQ-020 run_cnt SHALL be 8-bit, saturating at 255, cleared on entry to RUN from SWITCH, incremented every RUN cycle.
REQ-021 other_ready = other thread READY (including a same-cycle mem_done for it); thread_switch_available SHALL equal other_ready & run_cnt>=MIN_RUN in RUN, other_ready in STALL, 0 in SWITCH.
REQ-022 RUN, dc_miss, thread_switch_available: current -> WAITING, saved_pc[cur]=miss_pc, next state SWITCH.
REQ-023 RUN, dc_miss, not available: current -> WAITING, saved_pc[cur]=miss_pc, next state STALL.
REQ-024 SWITCH (exactly one cycle): thread_switch=1, load_pc_we=1, load_pc_new_pc=saved_pc[other]; at the closing edge cur_tid toggles, switch_count increments (wraps 16'hFFFF->0), next state RUN.
REQ-025 STALL, mem_done for current thread: current -> READY, next state RUN, no switch, run_cnt not cleared.
REQ-026 STALL, other thread READY (or becomes READY this cycle) and current still WAITING: next state SWITCH.
REQ-027 STALL, both events same cycle: current thread wins -> RUN, other marked READY.
REQ-028 mem_done for a WAITING thread SHALL set it READY in any state; mem_done for a non-WAITING thread SHALL be ignored.
REQ-029 dc_miss outside RUN SHALL be ignored.
REQ-030 Outputs thread_switch, load_pc_we SHALL be decoded from state only (no input-to-output path); thread_switch_available may be combinational from mem_done.
REQ-031 IDLE thread SHALL never be selected; with thread_en=2'b01 the block never leaves RUN/STALL.

Reset
REQ-032 rst_n low SHALL immediately force: state RUN, cur_tid 0, run_cnt 0, switch_count 0, thread_switch 0, load_pc_we 0, load_pc_new_pc 0, saved_pc = {RESET_PC1, RESET_PC0}, thread status READY where thread_en set else IDLE.
REQ-033 Reset mid-SWITCH or mid-STALL SHALL discard all outstanding misses; no pulse emitted in the first cycle after release.

Verification
REQ-034 thread_en=11, 10 cycles RUN, dc_miss miss_pc=0x40 -> next cycle thread_switch=1, load_pc_new_pc=0x100; following cycle cur_tid=1, switch_count=1.
REQ-035 thread_en=01, dc_miss -> STALL, thread_switch_available=0, no switch; mem_done tid0 -> RUN, cur_tid 0.
REQ-036 Switch at MIN_RUN=4, thread 1 misses 2 cycles later -> STALL (available=0); mem_done tid0 -> SWITCH, new_pc = thread 0 miss_pc.
REQ-037 STALL with mem_done current and other ready same cycle -> RUN, no thread_switch.
REQ-038 Force switch_count to 0xFFFF via 65535 switches (or backdoor) -> next switch reads 0x0000.
REQ-039 Assert rst_n low during SWITCH -> thread_switch drops same cycle, all outputs at REQ-032 values.

Source files
------------

// File: rtl/thread_switch_controller.sv
// -----------------------------------------------------------------------------
// thread_switch_controller
//
// Two-thread switch-on-miss controller. When the issuing thread takes a
// D-cache miss it is parked (WAITING) with its resume PC. If the other thread
// can run, and the current thread has held the pipeline for at least MIN_RUN
// cycles, the block emits a one-cycle flush/switch pulse that also reloads the
// fetch PC. Otherwise it stalls until either fill completes.
//
// Ports
//   clk                      clock, rising edge
//   rst_n                    asynchronous active-low reset
//   thread_en[1:0]           per-thread enable, stable outside reset
//   dc_miss / miss_pc        miss pulse for the current thread and its PC
//   mem_done / mem_done_tid  fill-complete pulse and owning thread
//   cur_tid                  thread currently issuing
//   thread_switch            one-cycle flush-and-switch pulse
//   thread_switch_available  the other thread could be switched to now
//   load_pc_we               PC overwrite strobe (coincides with thread_switch)
//   load_pc_new_pc           resume PC of the incoming thread
//   switch_count[15:0]       switches since reset, wrapping
// -----------------------------------------------------------------------------
module thread_switch_controller #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    MIN_RUN    = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC0  = 32'h0,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC1  = 32'h100
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            thread_en,
   input  logic                  dc_miss,
   input  logic [ADDR_WIDTH-1:0] miss_pc,
   input  logic                  mem_done,
   input  logic                  mem_done_tid,
   output logic                  cur_tid,
   output logic                  thread_switch,
   output logic                  thread_switch_available,
   output logic                  load_pc_we,
   output logic [ADDR_WIDTH-1:0] load_pc_new_pc,
   output logic [15:0]           switch_count
);

   typedef enum logic [1:0] {S_RUN, S_SWITCH, S_STALL} state_t;
   typedef enum logic [1:0] {T_IDLE, T_READY, T_WAITING} thr_status_t;

   localparam logic [7:0] MIN_RUN_C = 8'(MIN_RUN);

   state_t                state_q, state_d;
   thr_status_t           status_q   [2];
   thr_status_t           status_d   [2];
   logic [ADDR_WIDTH-1:0] saved_pc_q [2];
   logic [ADDR_WIDTH-1:0] saved_pc_d [2];
   logic [7:0]            run_cnt_q, run_cnt_d;
   logic                  cur_tid_d;
   logic [15:0]           switch_count_d;

   logic                  oth;
   logic                  done_cur;
   logic                  done_oth;
   logic                  other_ready;
   logic                  avail;

   assign oth = ~cur_tid;

   // A fill only counts when its thread is actually waiting; stray
   // completions for READY/IDLE threads are dropped.
   assign done_cur = mem_done && (mem_done_tid == cur_tid) && (status_q[cur_tid] == T_WAITING);
   assign done_oth = mem_done && (mem_done_tid == oth)     && (status_q[oth]     == T_WAITING);

   // A same-cycle fill for the other thread makes it eligible immediately.
   assign other_ready = (status_q[oth] == T_READY) || done_oth;

   always_comb begin
      state_d        = state_q;
      status_d       = status_q;
      saved_pc_d     = saved_pc_q;
      run_cnt_d      = run_cnt_q;
      cur_tid_d      = cur_tid;
      switch_count_d = switch_count;
      avail          = 1'b0;

      for (int i = 0; i < 2; i++) begin
         if (mem_done && (mem_done_tid == 1'(i)) && (status_q[i] == T_WAITING))
            status_d[i] = T_READY;
      end

      case (state_q)
         S_RUN: begin
            avail = other_ready && (run_cnt_q >= MIN_RUN_C);
            if (run_cnt_q != 8'hFF)
               run_cnt_d = run_cnt_q + 8'd1;
            if (dc_miss) begin
               status_d[cur_tid]   = T_WAITING;
               saved_pc_d[cur_tid] = miss_pc;
               state_d             = avail ? S_SWITCH : S_STALL;
            end
         end
         S_STALL: begin
            avail = other_ready;
            // Own fill takes priority over switching away.
            if (done_cur)
               state_d = S_RUN;
            else if (other_ready)
               state_d = S_SWITCH;
         end
         S_SWITCH: begin
            state_d        = S_RUN;
            cur_tid_d      = oth;
            switch_count_d = switch_count + 16'd1;
            run_cnt_d      = 8'd0;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_RUN;
         cur_tid       <= 1'b0;
         run_cnt_q     <= 8'd0;
         switch_count  <= 16'd0;
         saved_pc_q[0] <= RESET_PC0;
         saved_pc_q[1] <= RESET_PC1;
         status_q[0]   <= thread_en[0] ? T_READY : T_IDLE;
         status_q[1]   <= thread_en[1] ? T_READY : T_IDLE;
      end else begin
         state_q      <= state_d;
         cur_tid      <= cur_tid_d;
         run_cnt_q    <= run_cnt_d;
         switch_count <= switch_count_d;
         saved_pc_q   <= saved_pc_d;
         status_q     <= status_d;
      end
   end

   // Switch strobes come from state alone so no input reaches them
   // combinationally; the resume PC is driven only while switching.
   assign thread_switch           = (state_q == S_SWITCH);
   assign load_pc_we              = (state_q == S_SWITCH);
   assign load_pc_new_pc          = (state_q == S_SWITCH) ? saved_pc_q[oth] : '0;
   assign thread_switch_available = avail;

endmodule

// File: tb/tb_thread_switch_controller.sv
module tb_thread_switch_controller;

   logic        clk;
   logic        rst_n;
   logic [1:0]  thread_en;
   logic        dc_miss;
   logic [31:0] miss_pc;
   logic        mem_done;
   logic        mem_done_tid;
   logic        cur_tid;
   logic        thread_switch;
   logic        thread_switch_available;
   logic        load_pc_we;
   logic [31:0] load_pc_new_pc;
   logic [15:0] switch_count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [15:0] cnt;
   } exp_t;

   exp_t exp_q[$];

   thread_switch_controller #(
      .ADDR_WIDTH(32),
      .MIN_RUN   (4),
      .RESET_PC0 (32'h0),
      .RESET_PC1 (32'h100)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .thread_en              (thread_en),
      .dc_miss                (dc_miss),
      .miss_pc                (miss_pc),
      .mem_done               (mem_done),
      .mem_done_tid           (mem_done_tid),
      .cur_tid                (cur_tid),
      .thread_switch          (thread_switch),
      .thread_switch_available(thread_switch_available),
      .load_pc_we             (load_pc_we),
      .load_pc_new_pc         (load_pc_new_pc),
      .switch_count           (switch_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every switch pulse must match the oldest expected switch.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && thread_switch === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_switch: pulse seen with new_pc=%h, none expected", load_pc_new_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (load_pc_new_pc !== e.pc) begin
               n_fail++;
               $display("FAIL switch_new_pc: got %h expected %h", load_pc_new_pc, e.pc);
            end
            n_tests++;
            if (switch_count !== e.cnt) begin
               n_fail++;
               $display("FAIL switch_count_at_pulse: got %h expected %h", switch_count, e.cnt);
            end
            n_tests++;
            if (load_pc_we !== 1'b1) begin
               n_fail++;
               $display("FAIL load_pc_we_with_switch: got %b expected 1", load_pc_we);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] en);
      rst_n        = 1'b0;
      thread_en    = en;
      dc_miss      = 1'b0;
      miss_pc      = '0;
      mem_done     = 1'b0;
      mem_done_tid = 1'b0;
      cyc(2);
      rst_n = 1'b1;
   endtask

   task automatic pulse_miss(input logic [31:0] pc);
      dc_miss = 1'b1;
      miss_pc = pc;
      cyc(1);
      dc_miss = 1'b0;
      miss_pc = '0;
   endtask

   task automatic pulse_done(input logic tid);
      mem_done     = 1'b1;
      mem_done_tid = tid;
      cyc(1);
      mem_done     = 1'b0;
      mem_done_tid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      thread_en    = 2'b11;
      dc_miss      = 1'b0;
      miss_pc      = '0;
      mem_done     = 1'b0;
      mem_done_tid = 1'b0;
      #1;
      n_tests++;
      if (cur_tid !== 1'b0) begin n_fail++; $display("FAIL reset_cur_tid: got %b expected 0", cur_tid); end
      n_tests++;
      if (thread_switch !== 1'b0) begin n_fail++; $display("FAIL reset_thread_switch: got %b expected 0", thread_switch); end
      n_tests++;
      if (load_pc_we !== 1'b0) begin n_fail++; $display("FAIL reset_load_pc_we: got %b expected 0", load_pc_we); end
      n_tests++;
      if (load_pc_new_pc !== 32'h0) begin n_fail++; $display("FAIL reset_new_pc: got %h expected 0", load_pc_new_pc); end
      n_tests++;
      if (switch_count !== 16'h0) begin n_fail++; $display("FAIL reset_switch_count: got %h expected 0", switch_count); end
      n_tests++;
      if (thread_switch_available !== 1'b0) begin n_fail++; $display("FAIL reset_available: got %b expected 0", thread_switch_available); end
      cyc(2);
   endtask

   task automatic test_basic_switch();
      do_reset(2'b11);
      for (int k = 0; k < 7; k++) begin
         n_tests++;
         if (thread_switch_available !== (k >= 4)) begin
            n_fail++;
            $display("FAIL min_run_available: cycle %0d got %b expected %b", k, thread_switch_available, (k >= 4));
         end
         cyc(1);
      end
      cyc(3);
      exp_q.push_back('{pc: 32'h100, cnt: 16'h0});
      pulse_miss(32'h40);
      cyc(1);
      n_tests++;
      if (cur_tid !== 1'b1) begin n_fail++; $display("FAIL basic_cur_tid: got %b expected 1", cur_tid); end
      n_tests++;
      if (switch_count !== 16'd1) begin n_fail++; $display("FAIL basic_switch_count: got %h expected 1", switch_count); end
      n_tests++;
      if (thread_switch !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", thread_switch); end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_pending: %0d switches outstanding, expected 0", exp_q.size()); end
   endtask

   task automatic test_single_thread();
      do_reset(2'b01);
      cyc(6);
      n_tests++;
      if (thread_switch_available !== 1'b0) begin n_fail++; $display("FAIL single_avail_run: got %b expected 0", thread_switch_available); end
      pulse_miss(32'h20);
      n_tests++;
      if (thread_switch_available !== 1'b0) begin n_fail++; $display("FAIL single_avail_stall: got %b expected 0", thread_switch_available); end
      cyc(4);
      pulse_miss(32'h24);
      pulse_done(1'b1);
      pulse_done(1'b0);
      cyc(3);
      n_tests++;
      if (cur_tid !== 1'b0) begin n_fail++; $display("FAIL single_cur_tid: got %b expected 0", cur_tid); end
      n_tests++;
      if (switch_count !== 16'h0) begin n_fail++; $display("FAIL single_switch_count: got %h expected 0", switch_count); end
   endtask

   task automatic test_stall_then_switch();
      do_reset(2'b11);
      cyc(5);
      exp_q.push_back('{pc: 32'h100, cnt: 16'h0});
      pulse_miss(32'h44);
      cyc(3);
      n_tests++;
      if (cur_tid !== 1'b1) begin n_fail++; $display("FAIL stall_cur_tid_t1: got %b expected 1", cur_tid); end
      n_tests++;
      if (thread_switch_available !== 1'b0) begin n_fail++; $display("FAIL stall_avail_run: got %b expected 0", thread_switch_available); end
      pulse_miss(32'h180);
      n_tests++;
      if (thread_switch_available !== 1'b0) begin n_fail++; $display("FAIL stall_avail_stall: got %b expected 0", thread_switch_available); end
      exp_q.push_back('{pc: 32'h44, cnt: 16'h1});
      mem_done     = 1'b1;
      mem_done_tid = 1'b0;
      #1;
      n_tests++;
      if (thread_switch_available !== 1'b1) begin n_fail++; $display("FAIL stall_avail_on_done: got %b expected 1", thread_switch_available); end
      cyc(1);
      mem_done = 1'b0;
      cyc(1);
      n_tests++;
      if (cur_tid !== 1'b0) begin n_fail++; $display("FAIL stall_cur_tid_t0: got %b expected 0", cur_tid); end
      n_tests++;
      if (switch_count !== 16'd2) begin n_fail++; $display("FAIL stall_switch_count: got %h expected 2", switch_count); end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_pending: %0d switches outstanding, expected 0", exp_q.size()); end
   endtask

   task automatic test_simultaneous();
      do_reset(2'b11);
      cyc(1);
      pulse_miss(32'h70);
      pulse_done(1'b0);
      n_tests++;
      if (thread_switch !== 1'b0) begin n_fail++; $display("FAIL simul_no_switch: got %b expected 0", thread_switch); end
      n_tests++;
      if (cur_tid !== 1'b0) begin n_fail++; $display("FAIL simul_cur_tid: got %b expected 0", cur_tid); end
      n_tests++;
      if (thread_switch_available !== 1'b0) begin n_fail++; $display("FAIL simul_avail_cnt2: got %b expected 0", thread_switch_available); end
      cyc(2);
      n_tests++;
      if (thread_switch_available !== 1'b1) begin n_fail++; $display("FAIL simul_avail_cnt4: got %b expected 1", thread_switch_available); end
      exp_q.push_back('{pc: 32'h100, cnt: 16'h0});
      pulse_miss(32'h74);
      cyc(1);
      n_tests++;
      if (cur_tid !== 1'b1) begin n_fail++; $display("FAIL simul_cur_tid_after: got %b expected 1", cur_tid); end
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL simul_pending: %0d switches outstanding, expected 0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      do_reset(2'b11);
      cyc(5);
      force dut.switch_count = 16'hFFFF;
      #1;
      release dut.switch_count;
      n_tests++;
      if (switch_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", switch_count); end
      exp_q.push_back('{pc: 32'h100, cnt: 16'hFFFF});
      cyc(1);
      pulse_miss(32'h80);
      cyc(1);
      n_tests++;
      if (switch_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_count: got %h expected 0000", switch_count); end
      n_tests++;
      if (cur_tid !== 1'b1) begin n_fail++; $display("FAIL wrap_cur_tid: got %b expected 1", cur_tid); end
   endtask

   task automatic test_reset_mid_switch();
      do_reset(2'b11);
      cyc(5);
      pulse_miss(32'h90);
      n_tests++;
      if (thread_switch !== 1'b1) begin n_fail++; $display("FAIL rms_pulse_before: got %b expected 1", thread_switch); end
      n_tests++;
      if (load_pc_new_pc !== 32'h100) begin n_fail++; $display("FAIL rms_new_pc_before: got %h expected 100", load_pc_new_pc); end
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (thread_switch !== 1'b0) begin n_fail++; $display("FAIL rms_switch_drop: got %b expected 0", thread_switch); end
      n_tests++;
      if (load_pc_we !== 1'b0) begin n_fail++; $display("FAIL rms_we_drop: got %b expected 0", load_pc_we); end
      n_tests++;
      if (load_pc_new_pc !== 32'h0) begin n_fail++; $display("FAIL rms_new_pc: got %h expected 0", load_pc_new_pc); end
      n_tests++;
      if (cur_tid !== 1'b0) begin n_fail++; $display("FAIL rms_cur_tid: got %b expected 0", cur_tid); end
      n_tests++;
      if (switch_count !== 16'h0) begin n_fail++; $display("FAIL rms_switch_count: got %h expected 0", switch_count); end
      cyc(1);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (thread_switch !== 1'b0) begin n_fail++; $display("FAIL rms_post_release: cycle %0d got %b expected 0", k, thread_switch); end
         cyc(1);
      end
      cyc(5);
      exp_q.push_back('{pc: 32'h100, cnt: 16'h0});
      pulse_miss(32'hA0);
      cyc(1);
      n_tests++;
      if (cur_tid !== 1'b1) begin n_fail++; $display("FAIL rms_resume_cur_tid: got %b expected 1", cur_tid); end
      n_tests++;
      if (switch_count !== 16'd1) begin n_fail++; $display("FAIL rms_resume_count: got %h expected 1", switch_count); end
   endtask

   initial begin
      rst_n        = 1'b0;
      thread_en    = 2'b11;
      dc_miss      = 1'b0;
      miss_pc      = '0;
      mem_done     = 1'b0;
      mem_done_tid = 1'b0;
      test_reset();
      test_basic_switch();
      test_single_thread();
      test_stall_then_switch();
      test_simultaneous();
      test_wrap();
      test_reset_mid_switch();
      cyc(2);
      n_tests++;
      if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_pending: %0d switches outstanding, expected 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
